// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator: state encoding and default constants.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam int          DEF_ADDR_WIDTH   = 32;
  localparam int          DEF_CNT_WIDTH    = 32;
  localparam int          DEF_INST_BYTES   = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side signal bundle: the generator is the master, the IF stage / memory side is the slave.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  stall_i;
  logic                  fetch_ready_i;
  logic                  branch_valid_i;
  logic [ADDR_WIDTH-1:0] branch_target_i;
  logic                  trap_valid_i;
  logic                  halt_i;
  logic                  fetch_valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  misalign_o;
  logic [ADDR_WIDTH-1:0] misalign_addr_o;
  logic                  halted_o;
  logic [CNT_WIDTH-1:0]  fetch_cnt_o;

  modport master (
    input  stall_i, fetch_ready_i, branch_valid_i, branch_target_i, trap_valid_i, halt_i,
    output fetch_valid_o, pc_o, misalign_o, misalign_addr_o, halted_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, fetch_ready_i, branch_valid_i, branch_target_i, trap_valid_i, halt_i,
    input  fetch_valid_o, pc_o, misalign_o, misalign_addr_o, halted_o, fetch_cnt_o
  );
endinterface

// File: rtl/pc_gen_next_sel.sv
// pc_next_sel: combinational priority mux choosing next pc, misalign flag and next state.
module pc_gen_next_sel
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR[ADDR_WIDTH-1:0],
  parameter int                    INST_BYTES  = DEF_INST_BYTES
) (
  input  pc_state_e             state_r,
  input  logic [ADDR_WIDTH-1:0] pc_r,
  input  logic                  accept_s,
  input  logic                  branch_valid_s,
  input  logic [ADDR_WIDTH-1:0] branch_target_s,
  input  logic                  trap_valid_s,
  input  logic                  halt_s,
  output logic [ADDR_WIDTH-1:0] pc_next_s,
  output logic                  misalign_next_s,
  output pc_state_e             state_next_s
);

  localparam int                    ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INST_BYTES);

  logic target_misaligned_s;
  assign target_misaligned_s = |branch_target_s[ALIGN_BITS-1:0];

  // Priority: trap > aligned branch > misaligned branch > halt > accepted fetch > hold.
  always_comb begin
    pc_next_s       = pc_r;
    misalign_next_s = 1'b0;
    state_next_s    = state_r;
    case (state_r)
      PC_BOOT: begin
        state_next_s = PC_RUN;
      end
      PC_RUN: begin
        if (trap_valid_s) begin
          pc_next_s = TRAP_VECTOR;
        end else if (branch_valid_s && !target_misaligned_s) begin
          pc_next_s = branch_target_s;
        end else if (branch_valid_s) begin
          pc_next_s       = TRAP_VECTOR;
          misalign_next_s = 1'b1;
        end else if (halt_s) begin
          state_next_s = PC_HALT;
        end else if (accept_s) begin
          pc_next_s = pc_r + PC_INC;
        end else begin
          pc_next_s = pc_r;
        end
      end
      PC_HALT: begin
        // Only a redirect wakes the fetch unit; halt and handshake are ignored here.
        if (trap_valid_s) begin
          pc_next_s    = TRAP_VECTOR;
          state_next_s = PC_RUN;
        end else if (branch_valid_s && !target_misaligned_s) begin
          pc_next_s    = branch_target_s;
          state_next_s = PC_RUN;
        end else if (branch_valid_s) begin
          pc_next_s       = TRAP_VECTOR;
          misalign_next_s = 1'b1;
          state_next_s    = PC_RUN;
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: begin
        state_next_s = PC_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator at the head of IF: owns the PC, state, misalign and fetch-count registers.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR[ADDR_WIDTH-1:0],
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR[ADDR_WIDTH-1:0],
  parameter int                    INST_BYTES   = DEF_INST_BYTES,
  parameter int                    CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  pc_state_e             state_r;
  pc_state_e             state_next_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic                  misalign_r;
  logic                  misalign_next_s;
  logic [ADDR_WIDTH-1:0] misalign_addr_r;
  logic [CNT_WIDTH-1:0]  fetch_cnt_r;
  logic                  fetch_valid_s;
  logic                  accept_s;

  // The request is the only combinational output: registered RUN state gated by the stall.
  assign fetch_valid_s = (state_r == PC_RUN) && !bus.stall_i;
  assign accept_s      = fetch_valid_s && bus.fetch_ready_i;

  pc_gen_next_sel #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INST_BYTES  (INST_BYTES)
  ) u_next_sel (
    .state_r         (state_r),
    .pc_r            (pc_r),
    .accept_s        (accept_s),
    .branch_valid_s  (bus.branch_valid_i),
    .branch_target_s (bus.branch_target_i),
    .trap_valid_s    (bus.trap_valid_i),
    .halt_s          (bus.halt_i),
    .pc_next_s       (pc_next_s),
    .misalign_next_s (misalign_next_s),
    .state_next_s    (state_next_s)
  );

  // State and PC registers; reset discards whatever request was pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PC_BOOT;
      pc_r    <= RESET_VECTOR;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  // Misalign pulse and the sticky offending address.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r      <= 1'b0;
      misalign_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      misalign_r <= misalign_next_s;
      if (misalign_next_s) begin
        misalign_addr_r <= bus.branch_target_i;
      end
    end
  end

  // Accepted-fetch counter; counts accepts even when a redirect flushes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (accept_s) begin
      fetch_cnt_r <= fetch_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.fetch_valid_o   = fetch_valid_s;
  assign bus.pc_o            = pc_r;
  assign bus.misalign_o      = misalign_r;
  assign bus.misalign_addr_o = misalign_addr_r;
  assign bus.halted_o        = (state_r == PC_HALT);
  assign bus.fetch_cnt_o     = fetch_cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for the main flow and a 16-bit instance with a 2-bit counter for wrap cases.
module tb_pc_gen;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] maddr;
    logic        halted;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst32;
  logic rst16;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q16[$];

  pc_gen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) b32 ();
  pc_gen_if #(.ADDR_WIDTH(16), .CNT_WIDTH(2))  b16 ();

  pc_gen #(
    .ADDR_WIDTH(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
    .INST_BYTES(4), .CNT_WIDTH(32)
  ) dut32 (.clk(clk), .rst(rst32), .bus(b32));

  pc_gen #(
    .ADDR_WIDTH(16), .RESET_VECTOR(16'h0000), .TRAP_VECTOR(16'h0100),
    .INST_BYTES(4), .CNT_WIDTH(2)
  ) dut16 (.clk(clk), .rst(rst16), .bus(b16));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected instance and queue the outputs expected during that cycle.
  task automatic step(input bit sel, input logic r, input logic st, input logic rdy, input logic br,
                      input logic [31:0] tgt, input logic tr, input logic hl,
                      input logic ev, input logic [31:0] epc, input logic em, input logic [31:0] ema,
                      input logic eh, input logic [31:0] ecnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e = '{valid: ev, pc: epc, mis: em, maddr: ema, halted: eh, cnt: ecnt, name: nm};
    if (!sel) begin
      rst32 = r; b32.stall_i = st; b32.fetch_ready_i = rdy; b32.branch_valid_i = br;
      b32.branch_target_i = tgt; b32.trap_valid_i = tr; b32.halt_i = hl;
      q32.push_back(e);
    end else begin
      rst16 = r; b16.stall_i = st; b16.fetch_ready_i = rdy; b16.branch_valid_i = br;
      b16.branch_target_i = tgt[15:0]; b16.trap_valid_i = tr; b16.halt_i = hl;
      q16.push_back(e);
    end
  endtask

  // Monitor for the 32-bit instance: compares the presented outputs mid-cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      chk(e.name, "fetch_valid", {31'd0, b32.fetch_valid_o}, {31'd0, e.valid});
      chk(e.name, "pc", b32.pc_o, e.pc);
      chk(e.name, "misalign", {31'd0, b32.misalign_o}, {31'd0, e.mis});
      chk(e.name, "misalign_addr", b32.misalign_addr_o, e.maddr);
      chk(e.name, "halted", {31'd0, b32.halted_o}, {31'd0, e.halted});
      chk(e.name, "fetch_cnt", b32.fetch_cnt_o, e.cnt);
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk(e.name, "fetch_valid", {31'd0, b16.fetch_valid_o}, {31'd0, e.valid});
      chk(e.name, "pc", {16'd0, b16.pc_o}, e.pc);
      chk(e.name, "misalign", {31'd0, b16.misalign_o}, {31'd0, e.mis});
      chk(e.name, "halted", {31'd0, b16.halted_o}, {31'd0, e.halted});
      chk(e.name, "fetch_cnt", {30'd0, b16.fetch_cnt_o}, e.cnt);
    end
  end

  initial begin
    rst32 = 1'b1; rst16 = 1'b1;
    b32.stall_i = 1'b0; b32.fetch_ready_i = 1'b0; b32.branch_valid_i = 1'b0;
    b32.branch_target_i = 32'd0; b32.trap_valid_i = 1'b0; b32.halt_i = 1'b0;
    b16.stall_i = 1'b0; b16.fetch_ready_i = 1'b0; b16.branch_valid_i = 1'b0;
    b16.branch_target_i = 16'd0; b16.trap_valid_i = 1'b0; b16.halt_i = 1'b0;
    repeat (2) @(posedge clk);

    //   sel  rst  stl  rdy  br   target         trap hlt  | valid pc            mis  maddr          hlt  cnt
    step(1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "reset");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "boot_dead");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "seq_pc0");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0004, 1'b0,32'h0000_0000, 1'b0,32'd1, "seq_pc4");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0008, 1'b0,32'h0000_0000, 1'b0,32'd2, "seq_pc8");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "noready_1");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "noready_2");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "noready_3");
    step(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "stall_1");
    step(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "stall_2");
    step(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0040, 1'b1,1'b0,  1'b1, 32'h0000_000C, 1'b0,32'h0000_0000, 1'b0,32'd3, "trap_and_branch");
    step(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_0040, 1'b0,1'b0,  1'b1, 32'h0000_0100, 1'b0,32'h0000_0000, 1'b0,32'd4, "trap_wins");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0040, 1'b0,32'h0000_0000, 1'b0,32'd4, "branch_40");
    step(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0042, 1'b0,1'b0,  1'b1, 32'h0000_0044, 1'b0,32'h0000_0000, 1'b0,32'd5, "after_branch_44");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0100, 1'b1,32'h0000_0042, 1'b0,32'd6, "misalign_pulse");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0100, 1'b0,32'h0000_0042, 1'b0,32'd6, "misalign_cleared");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b1,  1'b1, 32'h0000_0100, 1'b0,32'h0000_0042, 1'b0,32'd6, "halt_with_accept");
    step(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b1,  1'b0, 32'h0000_0100, 1'b0,32'h0000_0042, 1'b1,32'd7, "halted");
    step(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0080, 1'b0,1'b0,  1'b0, 32'h0000_0100, 1'b0,32'h0000_0042, 1'b1,32'd7, "halted_branch");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0080, 1'b0,32'h0000_0042, 1'b0,32'd7, "resume_80");
    step(1'b0,1'b0,1'b1,1'b1,1'b1,32'h0000_0200, 1'b0,1'b0,  1'b0, 32'h0000_0080, 1'b0,32'h0000_0042, 1'b0,32'd7, "branch_in_stall");
    step(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0200, 1'b0,32'h0000_0042, 1'b0,32'd7, "stalled_redirect");
    step(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0200, 1'b0,32'h0000_0042, 1'b0,32'd7, "rst_mid_stall");
    step(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "post_rst_boot");
    step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "post_rst_run");

    // 16-bit instance: address wrap past 0xFFFC and 2-bit counter wrap.
    step(1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "w16_reset");
    step(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b0, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "w16_boot");
    step(1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_FFFC, 1'b0,1'b0,  1'b1, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd0, "w16_branch");
    step(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_FFFC, 1'b0,32'h0000_0000, 1'b0,32'd1, "w16_top");
    step(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0000, 1'b0,32'h0000_0000, 1'b0,32'd2, "w16_pc_wrap");
    step(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0004, 1'b0,32'h0000_0000, 1'b0,32'd3, "w16_cnt3");
    step(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,  1'b1, 32'h0000_0008, 1'b0,32'h0000_0000, 1'b0,32'd0, "w16_cnt_wrap");

    repeat (2) @(posedge clk);
    checks++;
    if (q32.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q32.size(), q16.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
